// File: rtl/vx_fpu_fma_req_stage_pkg.sv
// Shared FPU definitions for the FMA request path: op encoding, rounding-mode
// constants and the op -> control-triple decode.
package vx_fpu_fma_req_stage_pkg;

  typedef enum logic [2:0] {
    FMA_ADD   = 3'd0,
    FMA_SUB   = 3'd1,
    FMA_MUL   = 3'd2,
    FMA_MADD  = 3'd3,
    FMA_MSUB  = 3'd4,
    FMA_NMSUB = 3'd5,
    FMA_NMADD = 3'd6,
    FMA_RSVD  = 3'd7
  } fma_op_t;

  localparam logic [2:0] FRM_DYN = 3'd7;

  typedef struct packed {
    logic is_madd;
    logic is_sub;
    logic is_neg;
    logic bad_op;
  } fma_ctl_t;

  function automatic logic is_valid_frm(input logic [2:0] frm);
    return frm < 3'd5;
  endfunction

  function automatic fma_ctl_t fma_decode(input fma_op_t op);
    fma_ctl_t c;
    c = '0;
    case (op)
      FMA_SUB:   c.is_sub  = 1'b1;
      FMA_MUL:   c.is_neg  = 1'b1;
      FMA_MADD:  c.is_madd = 1'b1;
      FMA_MSUB:  begin c.is_madd = 1'b1; c.is_sub = 1'b1; end
      FMA_NMSUB: begin c.is_madd = 1'b1; c.is_sub = 1'b1; c.is_neg = 1'b1; end
      FMA_NMADD: begin c.is_madd = 1'b1; c.is_neg = 1'b1; end
      FMA_RSVD:  c.bad_op = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vx_fpu_fma_req_stage_skid_buf.sv
// Generic 2-entry skid buffer: output register plus one skid slot, so the
// upstream ready is a pure flop and never depends on ready_out.
module vx_skid_buf #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out
);

  logic             sk_valid;
  logic [DATAW-1:0] sk_data;
  logic             push, to_or, to_sk;

  assign ready_in = !sk_valid;
  assign push     = valid_in && !sk_valid;
  assign to_or    = push && (!valid_out || ready_out);
  assign to_sk    = push && valid_out && !ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      sk_valid  <= 1'b0;
    end else if (sk_valid) begin
      if (ready_out) sk_valid <= 1'b0;
    end else if (to_or) begin
      valid_out <= 1'b1;
    end else if (to_sk) begin
      sk_valid <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

  // Payload flops carry no reset; they are only observed under valid_out.
  always_ff @(posedge clk) begin
    if (sk_valid && ready_out) data_out <= sk_data;
    else if (to_or)            data_out <= data_in;
    if (to_sk)                 sk_data  <= data_in;
  end

endmodule

// File: rtl/vx_fpu_fma_req_stage.sv
// FMA request staging: decodes op and rounding mode at acceptance, drops
// all-masked requests, and registers the result through a skid buffer.
module vx_fpu_fma_req_stage
  import vx_fpu_fma_req_stage_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int TAG_WIDTH = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  fma_op_t                         op_in,
  input  logic [2:0]                      frm_in,
  input  logic [2:0]                      csr_frm,
  input  logic [NUM_LANES-1:0]            mask_in,
  input  logic [TAG_WIDTH-1:0]            tag_in,
  input  logic [NUM_LANES-1:0][31:0]      dataa_in,
  input  logic [NUM_LANES-1:0][31:0]      datab_in,
  input  logic [NUM_LANES-1:0][31:0]      datac_in,
  output logic                            valid_out,
  input  logic                            ready_out,
  output logic                            is_madd,
  output logic                            is_sub,
  output logic                            is_neg,
  output logic [2:0]                      frm,
  output logic                            illegal,
  output logic [NUM_LANES-1:0]            mask_out,
  output logic [TAG_WIDTH-1:0]            tag_out,
  output logic [NUM_LANES-1:0][31:0]      dataa,
  output logic [NUM_LANES-1:0][31:0]      datab,
  output logic [NUM_LANES-1:0][31:0]      datac,
  output logic [15:0]                     drop_cnt
);

  typedef struct packed {
    logic                       illegal;
    logic [2:0]                 frm;
    logic                       is_madd;
    logic                       is_sub;
    logic                       is_neg;
    logic [TAG_WIDTH-1:0]       tag;
    logic [NUM_LANES-1:0]       mask;
    logic [NUM_LANES-1:0][31:0] dataa;
    logic [NUM_LANES-1:0][31:0] datab;
    logic [NUM_LANES-1:0][31:0] datac;
  } req_t;

  localparam int DATAW = $bits(req_t);

  fma_ctl_t   ctl;
  logic [2:0] frm_res;
  logic       accept, enq, drop;
  req_t       req_d, req_q;

  assign ctl     = fma_decode(op_in);
  assign frm_res = (frm_in == FRM_DYN) ? csr_frm : frm_in;
  assign accept  = valid_in && ready_in;
  assign enq     = valid_in && (mask_in != '0);
  assign drop    = accept && (mask_in == '0);

  always_comb begin
    req_d         = '0;
    req_d.illegal = ctl.bad_op || !is_valid_frm(frm_res);
    req_d.frm     = frm_res;
    req_d.is_madd = ctl.is_madd;
    req_d.is_sub  = ctl.is_sub;
    req_d.is_neg  = ctl.is_neg;
    req_d.tag     = tag_in;
    req_d.mask    = mask_in;
    req_d.dataa   = dataa_in;
    req_d.datab   = datab_in;
    req_d.datac   = datac_in;
  end

  // Masked-out requests never enter the buffer but still see the same ready.
  vx_skid_buf #(.DATAW(DATAW)) skid (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (enq),
    .ready_in  (ready_in),
    .data_in   (req_d),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (req_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          drop_cnt <= '0;
    else if (drop && drop_cnt != '1)    drop_cnt <= drop_cnt + 16'd1;
  end

  assign illegal  = req_q.illegal;
  assign frm      = req_q.frm;
  assign is_madd  = req_q.is_madd;
  assign is_sub   = req_q.is_sub;
  assign is_neg   = req_q.is_neg;
  assign tag_out  = req_q.tag;
  assign mask_out = req_q.mask;
  assign dataa    = req_q.dataa;
  assign datab    = req_q.datab;
  assign datac    = req_q.datac;

endmodule
